// File: rtl/fetch_decode_queue_pkg.sv
// Shared definitions for the fetch/decode instruction queue: entry layout and NOP encoding.
package fetch_decode_queue_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0;
  localparam int          FDQ_ENTRY_W = 97;

  // Bit offsets of each field inside the packed entry word.
  localparam int OFF_PRED_PC    = 0;
  localparam int OFF_PRED_TAKEN = 32;
  localparam int OFF_PCPLUS4    = 33;
  localparam int OFF_INSTR      = 65;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } fdq_entry_t;

endpackage

// File: rtl/fetch_decode_queue_storage.sv
// DEPTH x W register file for the instruction queue: one clocked write port, one async read port.
module fdq_storage #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 97
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // No reset: occupancy is tracked by the pointers, stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue with flush on redirect.
// Optional macro FDQ_BYPASS_EN: same-cycle pass-through of enq_* to the D outputs when empty.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_valid,
  input  logic [31:0]   enq_instr,
  input  logic [31:0]   enq_pcplus4,
  input  logic          enq_pred_taken,
  input  logic [31:0]   enq_pred_pc,
  output logic          enq_ready,
  input  logic          deq_ready,
  output logic          deq_valid,
  output logic [31:0]   instrD,
  output logic [31:0]   pcplus4D,
  output logic          pred_takenD,
  output logic [31:0]   pred_pcD,
  input  logic          flush,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic                   empty, full, byp, do_enq, do_deq;
  fdq_entry_t             wentry;
  logic [FDQ_ENTRY_W-1:0] rdata;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

`ifdef FDQ_BYPASS_EN
  assign byp = empty && enq_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign enq_ready = !full;
  assign deq_valid = !empty || byp;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign do_enq = enq_valid && !full && !flush && !(byp && deq_ready);
  assign do_deq = deq_ready && !empty && !flush;

  assign wentry = '{instr:      enq_instr,
                    pcplus4:    enq_pcplus4,
                    pred_taken: enq_pred_taken,
                    pred_pc:    enq_pred_pc};

  fdq_storage #(.DEPTH(DEPTH), .AW(AW), .W(FDQ_ENTRY_W)) u_storage (
    .clk   (clk),
    .we    (do_enq),
    .waddr (wr_ptr),
    .wdata (wentry),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    instrD      = NOP_INSTR;
    pcplus4D    = '0;
    pred_takenD = 1'b0;
    pred_pcD    = '0;
    if (byp) begin
      instrD      = enq_instr;
      pcplus4D    = enq_pcplus4;
      pred_takenD = enq_pred_taken;
      pred_pcD    = enq_pred_pc;
    end else if (!empty) begin
      instrD      = rdata[OFF_INSTR +: 32];
      pcplus4D    = rdata[OFF_PCPLUS4 +: 32];
      pred_takenD = rdata[OFF_PRED_TAKEN];
      pred_pcD    = rdata[OFF_PRED_PC +: 32];
    end
  end

endmodule
